alu_sequencer: RTL and testbench

Multi-cycle controller that owns the shared ALU and sequences every operation issued to it. Accepts one operation per start handshake and drives the ALU's select and operand inputs. Single-pass ops (ADD/SUB/AND/OR/XOR) run through the ALU once. MUL and DIV run as 32-iteration shift-add and restoring-divide loops, using the ALU's add/subtract each iteration. Results land in the Z_low/Z_high register pair read by the datapath.

---
 rtl/alu_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: owns the shared ALU and sequences single-pass,
// shift-add multiply and restoring-divide operations through it.
module alu_sequencer #(
  parameter int          word_size = 32,
  parameter logic [5:0]  SEL_IDLE  = 6'd63
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 start,
  input  logic [5:0]           op,
  input  logic [word_size-1:0] a_in,
  input  logic [word_size-1:0] b_in,
  output logic [5:0]           alu_sel,
  output logic [word_size-1:0] alu_a,
  output logic [word_size-1:0] alu_b,
  input  logic [word_size-1:0] alu_low,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [word_size-1:0] z_low,
  output logic [word_size-1:0] z_high
);

  localparam int W = word_size;

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_DIV = 6'd2;
  localparam logic [5:0] OP_MUL = 6'd6;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    EXEC,
    DONE
  } state_t;

  state_t         state;
  logic [5:0]     op_r;
  logic [W-1:0]   b_r;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic [4:0]     cnt;

  logic           accept;
  logic           illegal;
  logic           div_zero;
  logic           is_iter;
  logic [W-1:0]   nhi;
  logic [W-1:0]   nlo;

  // hi/lo hold acc/mq for MUL and rem/quo for DIV; lo holds A otherwise
  function automatic logic [2*W-1:0] pass_ops(
    input logic [5:0]   o,
    input logic [W-1:0] h,
    input logic [W-1:0] l,
    input logic [W-1:0] b
  );
    logic [W-1:0] pa;
    logic [W-1:0] pb;
    pa = l;
    pb = b;
    unique case (1'b1)
      o == OP_MUL: begin
        pa = h;
        pb = l[0] ? b : '0;
      end
      o == OP_DIV: begin
        pa = {h[W-2:0], l[W-1]};
        pb = b;
      end
      default: ;
    endcase
    return {pa, pb};
  endfunction

  function automatic logic [5:0] alu_code(input logic [5:0] o);
    logic [5:0] c;
    c = o;
    unique case (1'b1)
      o == OP_MUL: c = OP_ADD;
      o == OP_DIV: c = OP_SUB;
      default: ;
    endcase
    return c;
  endfunction

  assign accept   = start && (state == IDLE || state == DONE);
  assign illegal  = op > OP_MUL;
  assign div_zero = (op == OP_DIV) && (b_in == '0);
  assign is_iter  = (op_r == OP_MUL) || (op_r == OP_DIV);

  always_comb begin
    nhi = hi;
    nlo = lo;
    unique case (1'b1)
      op_r == OP_MUL: begin
        {nhi, nlo} = {(alu_low < alu_a), alu_low, lo[W-1:1]};
      end
      op_r == OP_DIV: begin
        // alu_a carries the shifted remainder; hi[W-1] is its lost msb
        if (hi[W-1] || alu_a >= b_r) begin
          nhi = alu_low;
          nlo = {lo[W-2:0], 1'b1};
        end else begin
          nhi = alu_a;
          nlo = {lo[W-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state   <= IDLE;
      op_r    <= '0;
      b_r     <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      z_low   <= '0;
      z_high  <= '0;
      alu_sel <= SEL_IDLE;
      alu_a   <= '0;
      alu_b   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          alu_sel <= SEL_IDLE;
          if (accept) begin
            op_r <= op;
            b_r  <= b_in;
            hi   <= '0;
            lo   <= a_in;
            cnt  <= '0;
            err  <= 1'b0;
            unique case (1'b1)
              illegal: begin
                state  <= DONE;
                done   <= 1'b1;
                err    <= 1'b1;
                z_low  <= '0;
                z_high <= '0;
              end
              div_zero: begin
                state  <= DONE;
                done   <= 1'b1;
                err    <= 1'b1;
                z_low  <= '1;
                z_high <= a_in;
              end
              default: begin
                state <= SETUP;
                busy  <= 1'b1;
                {alu_a, alu_b} <= pass_ops(op, '0, a_in, b_in);
              end
            endcase
          end
        end
        SETUP: begin
          state   <= EXEC;
          alu_sel <= alu_code(op_r);
        end
        EXEC: begin
          alu_sel <= SEL_IDLE;
          if (!is_iter) begin
            z_low  <= alu_low;
            z_high <= '0;
            state  <= DONE;
            done   <= 1'b1;
            busy   <= 1'b0;
          end else begin
            hi <= nhi;
            lo <= nlo;
            if (cnt == 5'd31) begin
              z_high <= nhi;
              z_low  <= nlo;
              state  <= DONE;
              done   <= 1'b1;
              busy   <= 1'b0;
            end else begin
              cnt   <= cnt + 5'd1;
              state <= SETUP;
              {alu_a, alu_b} <= pass_ops(op_r, nhi, nlo, b_r);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors against alu_sequencer
// with a behavioural ALU on its select/operand outputs.
module tb_alu_sequencer;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  op = '0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [5:0]  alu_sel;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_low;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] z_low;
  logic [31:0] z_high;

  int n_chk = 0;
  int n_fail = 0;
  int cyc;
  logic [5:0] sel_setup;
  logic [5:0] sel_exec;

  alu_sequencer dut (
    .clock   (clock),
    .clear_n (clear_n),
    .start   (start),
    .op      (op),
    .a_in    (a_in),
    .b_in    (b_in),
    .alu_sel (alu_sel),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_low (alu_low),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .z_low   (z_low),
    .z_high  (z_high)
  );

  always #5 clock = ~clock;

  always_comb begin
    alu_low = '0;
    case (alu_sel)
      6'd0: alu_low = alu_a + alu_b;
      6'd1: alu_low = alu_a - alu_b;
      6'd3: alu_low = alu_a & alu_b;
      6'd4: alu_low = alu_a | alu_b;
      6'd5: alu_low = alu_a ^ alu_b;
      default: alu_low = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_done(inout int c);
    do begin
      @(posedge clock);
      #1 c++;
      if (c == 2) sel_exec = alu_sel;
    end while (!done && c < 200);
    check("done_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic run_op(input logic [5:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int c);
    @(negedge clock);
    op = o;
    a_in = a;
    b_in = b;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    c = 1;
    sel_setup = alu_sel;
    if (!done) wait_done(c);
  endtask

  initial begin
    #12;
    check("rst_ctl", {61'd0, busy, done, err}, 64'd0);
    check("rst_z", {z_high, z_low}, 64'd0);
    check("rst_sel", {58'd0, alu_sel}, 64'd63);
    check("rst_ops", {alu_a, alu_b}, 64'd0);
    @(negedge clock);
    clear_n = 1'b1;

    run_op(6'd0, 32'd5, 32'd7, cyc);
    check("add_cyc", cyc, 3);
    check("add_z", {z_high, z_low}, 64'd12);
    check("add_err", {63'd0, err}, 64'd0);
    check("add_sel_setup", {58'd0, sel_setup}, 64'd63);
    check("add_sel_exec", {58'd0, sel_exec}, 64'd0);
    @(posedge clock);
    #1 check("done_pulse", {63'd0, done}, 64'd0);
    check("add_hold", {z_high, z_low}, 64'd12);

    run_op(6'd1, 32'd3, 32'd5, cyc);
    check("sub_z", {z_high, z_low}, 64'h00000000_FFFFFFFE);
    check("sub_sel_exec", {58'd0, sel_exec}, 64'd1);

    run_op(6'd5, 32'hF0F0F0F0, 32'hFFFF0000, cyc);
    check("xor_z", {z_high, z_low}, 64'h00000000_0F0FF0F0);
    check("xor_sel_exec", {58'd0, sel_exec}, 64'd5);

    run_op(6'd4, 32'h0000_00F0, 32'h0000_0F00, cyc);
    check("or_z", {z_high, z_low}, 64'h0000_0FF0);
    run_op(6'd3, 32'h0000_0FF0, 32'h0000_00FF, cyc);
    check("and_z", {z_high, z_low}, 64'h0000_00F0);

    run_op(6'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    check("mul_cyc", cyc, 65);
    check("mul_max_z", {z_high, z_low}, 64'hFFFFFFFE_00000001);
    check("mul_sel_exec", {58'd0, sel_exec}, 64'd0);

    run_op(6'd6, 32'd6, 32'd7, cyc);
    check("mul_6x7", {z_high, z_low}, 64'd42);

    run_op(6'd2, 32'd100, 32'd7, cyc);
    check("div_cyc", cyc, 65);
    check("div_z", {z_high, z_low}, {32'd2, 32'd14});
    check("div_err", {63'd0, err}, 64'd0);
    check("div_sel_exec", {58'd0, sel_exec}, 64'd1);

    run_op(6'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    check("div_max_z", {z_high, z_low}, 64'd1);

    run_op(6'd2, 32'd9, 32'd0, cyc);
    check("dz_cyc", cyc, 1);
    check("dz_err", {63'd0, err}, 64'd1);
    check("dz_z", {z_high, z_low}, {32'd9, 32'hFFFFFFFF});

    run_op(6'd7, 32'd1, 32'd2, cyc);
    check("ill_cyc", cyc, 1);
    check("ill_err", {63'd0, err}, 64'd1);
    check("ill_z", {z_high, z_low}, 64'd0);
    @(posedge clock);
    #1 check("ill_err_hold", {62'd0, err, done}, 64'd2);

    run_op(6'd0, 32'd1, 32'd1, cyc);
    check("clr_err", {63'd0, err}, 64'd0);
    check("clr_z", {z_high, z_low}, 64'd2);

    @(negedge clock);
    op = 6'd2;
    a_in = 32'd100;
    b_in = 32'd7;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cyc = 1;
    repeat (9) begin
      @(posedge clock);
      #1 cyc++;
    end
    op = 6'd0;
    a_in = 32'd1;
    b_in = 32'd1;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cyc++;
    wait_done(cyc);
    check("busy_ign_cyc", cyc, 65);
    check("busy_ign_z", {z_high, z_low}, {32'd2, 32'd14});

    @(negedge clock);
    op = 6'd0;
    a_in = 32'd1;
    b_in = 32'd2;
    start = 1'b1;
    @(posedge clock);
    #1 op = 6'd1;
    a_in = 32'd10;
    b_in = 32'd3;
    cyc = 1;
    wait_done(cyc);
    check("b2b_cyc1", cyc, 3);
    check("b2b_z1", {z_high, z_low}, 64'd3);
    cyc = 0;
    wait_done(cyc);
    start = 1'b0;
    check("b2b_cyc2", cyc, 3);
    check("b2b_z2", {z_high, z_low}, 64'd7);

    @(negedge clock);
    op = 6'd6;
    a_in = 32'd6;
    b_in = 32'd7;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (20) @(posedge clock);
    #1 clear_n = 1'b0;
    #1;
    check("mrst_ctl", {61'd0, busy, done, err}, 64'd0);
    check("mrst_z", {z_high, z_low}, 64'd0);
    check("mrst_sel", {58'd0, alu_sel}, 64'd63);
    check("mrst_ops", {alu_a, alu_b}, 64'd0);
    @(negedge clock);
    clear_n = 1'b1;
    run_op(6'd0, 32'd2, 32'd2, cyc);
    check("post_rst_cyc", cyc, 3);
    check("post_rst_z", {z_high, z_low}, 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
